level_sequencer: RTL and testbench

- Parametrised game-progression controller: tracks how many level mechanisms (bridges, pillars, ...) are formed and hands redraw requests to the map drawer.
- Generalises the fixed bridge/pillar controller to NUM_STAGES activation points held in parameter tables.
- Adds rising-edge activation, a sprite-death respawn path and a one-shot win redraw.
- Sits between the sprite/keyboard logic and the map drawer.

---
 rtl/level_sequencer.sv | 100 ++++++++++
 tb/tb_level_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/level_sequencer.sv
// level_sequencer: stage/phase controller that steps level mechanisms and requests map redraws
module level_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter logic [NUM_STAGES*X_W-1:0] ACT_X = {9'd124, 9'd180, 9'd187, 9'd124},
    parameter logic [NUM_STAGES*Y_W-1:0] ACT_Y = {8'd158, 8'd214, 8'd149, 8'd158},
    parameter int GOAL_X_MIN = 156,
    parameter int GOAL_Y_MAX = 55,
    localparam int SW = $clog2(NUM_STAGES + 1)
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           activate,
    input  logic           spriteDead,
    input  logic           doneRedraw,
    input  logic [X_W-1:0] X,
    input  logic [Y_W-1:0] Y,
    output logic           drawMap,
    output logic [SW-1:0]  stage,
    output logic [1:0]     phase,
    output logic           finished,
    output logic           respawn
);
    typedef enum logic [1:0] {REDRAW = 2'd0, PLAY = 2'd1, WIN_DRAW = 2'd2, WON = 2'd3} phase_t;

    phase_t phaseQ, phaseD;
    logic [SW-1:0] stageQ, stageD;
    logic actQ, actRise, respawnQ, respawnD, hitFwd, hitBack, atGoal;
    logic [NUM_STAGES-1:0] hit;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_hit
        assign hit[i] = (X == ACT_X[i*X_W +: X_W]) && (Y == ACT_Y[i*Y_W +: Y_W]);
    end

    assign actRise = activate & ~actQ;
    assign atGoal = (X >= X_W'(GOAL_X_MIN)) && (Y <= Y_W'(GOAL_Y_MAX));

    // Select the activation points just ahead of and just behind the current stage
    always_comb begin
        hitFwd = 1'b0;
        hitBack = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stageQ == SW'(i)) hitFwd = hit[i];
            if (stageQ == SW'(i + 1)) hitBack = hit[i];
        end
    end

    // Next phase/stage; death outranks everything, forward outranks back
    always_comb begin
        phaseD = phaseQ;
        stageD = stageQ;
        respawnD = 1'b0;
        if (phaseQ == REDRAW) begin
            if (spriteDead) begin
                stageD = '0;
                respawnD = 1'b1;
            end else if (doneRedraw) begin
                phaseD = PLAY;
            end
        end else if (phaseQ == PLAY) begin
            if (spriteDead) begin
                stageD = '0;
                phaseD = REDRAW;
                respawnD = 1'b1;
            end else if (stageQ < SW'(NUM_STAGES) && hitFwd && actRise) begin
                stageD = stageQ + 1'b1;
                phaseD = REDRAW;
            end else if (stageQ != '0 && hitBack && actRise) begin
                stageD = stageQ - 1'b1;
                phaseD = REDRAW;
            end else if (stageQ == SW'(NUM_STAGES) && atGoal) begin
                phaseD = WIN_DRAW;
            end
        end else if (phaseQ == WIN_DRAW) begin
            phaseD = doneRedraw ? WON : WIN_DRAW;
        end
    end

    // State register; the key history resets high so a key held through reset is not an edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            phaseQ <= REDRAW;
            stageQ <= '0;
            actQ <= 1'b1;
            respawnQ <= 1'b0;
        end else begin
            phaseQ <= phaseD;
            stageQ <= stageD;
            actQ <= activate;
            respawnQ <= respawnD;
        end
    end

    assign drawMap = (phaseQ == REDRAW) || (phaseQ == WIN_DRAW);
    assign finished = (phaseQ == WON);
    assign stage = stageQ;
    assign phase = phaseQ;
    assign respawn = respawnQ;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed scoreboard bench for level_sequencer
module tb_level_sequencer;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic activate = 1'b0;
    logic spriteDead = 1'b0;
    logic doneRedraw = 1'b0;
    logic [8:0] X = '0;
    logic [7:0] Y = '0;
    logic drawMap, finished, respawn;
    logic [2:0] stage;
    logic [1:0] phase;

    typedef struct {
        string nm;
        logic [1:0] ph;
        logic [2:0] st;
        logic dr;
        logic fi;
        logic rs;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    level_sequencer dut (
        .clock(clock),
        .resetn(resetn),
        .activate(activate),
        .spriteDead(spriteDead),
        .doneRedraw(doneRedraw),
        .X(X),
        .Y(Y),
        .drawMap(drawMap),
        .stage(stage),
        .phase(phase),
        .finished(finished),
        .respawn(respawn)
    );

    always #5 clock = ~clock;

    task automatic step(input string nm, input logic rn, input logic act, input logic dead,
                        input logic done, input int x, input int y,
                        input logic [1:0] ePh, input logic [2:0] eSt, input logic eRs);
        exp_t e;
        resetn = rn;
        activate = act;
        spriteDead = dead;
        doneRedraw = done;
        X = 9'(x);
        Y = 8'(y);
        @(posedge clock);
        #1;
        e.nm = nm;
        e.ph = ePh;
        e.st = eSt;
        e.dr = (ePh == 2'd0) || (ePh == 2'd2);
        e.fi = (ePh == 2'd3);
        e.rs = eRs;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({phase, stage, drawMap, finished, respawn} != {e.ph, e.st, e.dr, e.fi, e.rs}) begin
                errors++;
                $display("FAIL %s: got phase=%0d stage=%0d drawMap=%0b finished=%0b respawn=%0b, want phase=%0d stage=%0d drawMap=%0b finished=%0b respawn=%0b",
                         e.nm, phase, stage, drawMap, finished, respawn, e.ph, e.st, e.dr, e.fi, e.rs);
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: sequence did not complete, checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        step("reset",        0, 0, 0, 0,   0,   0,   0, 0, 0);
        if (phase !== 2'd0 || stage !== 3'd0 || respawn !== 1'b0 || drawMap !== 1'b1 || finished !== 1'b0) begin
            errors++;
            $display("FAIL resetState: phase=%0d stage=%0d respawn=%0b drawMap=%0b finished=%0b",
                     phase, stage, respawn, drawMap, finished);
        end
        step("done0",        1, 0, 0, 1,   0,   0,   1, 0, 0);
        step("fwd0",         1, 1, 0, 0,   124, 158, 0, 1, 0);
        step("redrawHeld",   1, 1, 0, 1,   124, 158, 1, 1, 0);
        step("heldNoStep",   1, 1, 0, 0,   124, 158, 1, 1, 0);
        step("release",      1, 0, 0, 0,   124, 158, 1, 1, 0);
        step("back1",        1, 1, 0, 0,   124, 158, 0, 0, 0);
        step("done1",        1, 1, 0, 1,   124, 158, 1, 0, 0);
        step("offPoint",     1, 0, 0, 0,   187, 149, 1, 0, 0);
        step("fwd0b",        1, 1, 0, 0,   124, 158, 0, 1, 0);
        step("done2",        1, 0, 0, 1,   124, 158, 1, 1, 0);
        step("fwd1",         1, 1, 0, 0,   187, 149, 0, 2, 0);
        step("done3",        1, 0, 0, 1,   187, 149, 1, 2, 0);
        step("death",        1, 0, 1, 0,   187, 149, 0, 0, 1);
        step("deathEnd",     1, 0, 0, 0,   187, 149, 0, 0, 0);
        step("deathBeatsDone",1,0, 1, 1,   187, 149, 0, 0, 1);
        step("done4",        1, 0, 0, 1,   187, 149, 1, 0, 0);
        step("climb1",       1, 1, 0, 0,   124, 158, 0, 1, 0);
        step("climbD1",      1, 0, 0, 1,   124, 158, 1, 1, 0);
        step("climb2",       1, 1, 0, 0,   187, 149, 0, 2, 0);
        step("climbD2",      1, 0, 0, 1,   187, 149, 1, 2, 0);
        step("climb3",       1, 1, 0, 0,   180, 214, 0, 3, 0);
        step("climbD3",      1, 0, 0, 1,   180, 214, 1, 3, 0);
        step("climb4",       1, 1, 0, 0,   124, 158, 0, 4, 0);
        step("climbD4",      1, 0, 0, 1,   155, 55,  1, 4, 0);
        step("goalMissX",    1, 0, 0, 0,   155, 55,  1, 4, 0);
        step("goalMissY",    1, 0, 0, 0,   156, 56,  1, 4, 0);
        step("goalEdge",     1, 0, 0, 0,   156, 55,  2, 4, 0);
        step("winDeadIgn",   1, 0, 1, 0,   160, 50,  2, 4, 0);
        step("winDone",      1, 0, 0, 1,   160, 50,  3, 4, 0);
        step("wonAbsorb",    1, 1, 1, 1,   124, 158, 3, 4, 0);
        step("wonAbsorb2",   1, 0, 0, 0,   124, 158, 3, 4, 0);
        step("resetHeldKey", 0, 1, 0, 0,   0,   0,   0, 0, 0);
        step("doneHeldKey",  1, 1, 0, 1,   0,   0,   1, 0, 0);
        step("slideOnto",    1, 1, 0, 0,   124, 158, 1, 0, 0);
        step("slideRelease", 1, 0, 0, 0,   160, 50,  1, 0, 0);
        step("fwdAgain",     1, 1, 0, 0,   124, 158, 0, 1, 0);
        step("resetMid",     0, 0, 0, 0,   124, 158, 0, 0, 0);
        @(negedge clock);
        #1;
        if (checks != 38) begin
            errors++;
            $display("FAIL checkCount: got %0d comparisons, want 38", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $display(errors == 0 ? "PASS" : "FAIL");
        $finish;
    end
endmodule
